i2c_apb_master: RTL and testbench

- Synthesizable APB initiator that converts a simple valid/ready request stream into single APB transfers toward i2c_register_block.
- Used by the on-chip sequencer and the system bench to program prescaler, cmd, transmit and address_rw, and to poll status and receive.
- Returns one response per request, carrying read data and an error flag.
- Supports slave wait states, a bus timeout, and the late read data that i2c_register_block presents.

---
 rtl/i2c_apb_pkg.sv | 33 +++
 rtl/i2c_apb_master.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_apb_master.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_apb_pkg.sv
// i2c_apb_pkg
//   Shared definitions for the APB initiator that programs i2c_register_block.
//   - FSM state encoding (plain localparams so legacy tools and waveform
//     viewers see stable numeric codes).
//   - Register map of i2c_register_block.
//   - cnt_width(): width helper for the counters. It never returns 0 bits,
//     so a disabled feature (parameter 0) still yields a legal vector.
package i2c_apb_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_RDWAIT = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  // i2c_register_block register addresses
  localparam logic [7:0] REG_PRESCALER  = 8'h00;
  localparam logic [7:0] REG_CMD        = 8'h01;
  localparam logic [7:0] REG_TRANSMIT   = 8'h02;
  localparam logic [7:0] REG_RECEIVE    = 8'h03;
  localparam logic [7:0] REG_ADDRESS_RW = 8'h04;
  localparam logic [7:0] REG_STATUS     = 8'h05;

  // Bits needed to hold 0..n; at least one bit.
  function automatic int cnt_width(input int n);
    if (n <= 0) begin
      return 1;
    end
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/i2c_apb_master.sv
// i2c_apb_master
//   Converts a valid/ready request stream into single APB transfers and
//   returns exactly one response per accepted request. Only one transfer is
//   ever in flight: the next request is accepted no earlier than the cycle
//   after the previous response handshake.
//
//   Ports
//     pclk_i, preset_i           clock, synchronous active-high reset
//     req_valid_i / req_ready_o  request handshake
//     req_write_i                1 = write, 0 = read
//     req_addr_i, req_wdata_i    request address / write data
//     rsp_valid_o / rsp_ready_i  response handshake
//     rsp_rdata_o                read data (0 for writes and timeouts)
//     rsp_err_o                  transfer was aborted by the timeout
//     busy_o                     FSM is not idle
//     psel_o, penable_o,
//     pwrite_o, paddr_o,
//     pwdata_o                   APB request side
//     prdata_i, pready_i         APB completion side
//
//   Parameters
//     TIMEOUT_CYCLES  ACCESS cycles with pready_i low before abort, 0 = never
//     RDATA_DELAY     cycles after the completing ACCESS edge at which
//                     prdata_i is sampled (1 for i2c_register_block, which
//                     registers its read data on the access edge)
module i2c_apb_master
  import i2c_apb_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RDATA_DELAY    = 1
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  localparam int WAIT_W = cnt_width(TIMEOUT_CYCLES);
  localparam int DLY_W  = cnt_width(RDATA_DELAY);

  // Counter values on which the timeout fires / the delayed data is sampled.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [DLY_W-1:0]  DLY_LAST  =
    (RDATA_DELAY > 0) ? DLY_W'(RDATA_DELAY - 1) : '0;

  logic [2:0]        state_reg,     state_next;
  logic [WAIT_W-1:0] wait_cnt_reg,  wait_cnt_next;
  logic [DLY_W-1:0]  dly_cnt_reg,   dly_cnt_next;
  logic              psel_reg,      psel_next;
  logic              penable_reg,   penable_next;
  logic              pwrite_reg,    pwrite_next;
  logic [ADDR_W-1:0] paddr_reg,     paddr_next;
  logic [DATA_W-1:0] pwdata_reg,    pwdata_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg,   rsp_err_next;

  logic accept;

  // Ready is combinational so a waiting requester is taken on the first idle
  // cycle; it is masked during reset so nothing is accepted into a clearing FSM.
  assign req_ready_o = (state_reg == ST_IDLE) && !rsp_valid_reg && !preset_i;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    dly_cnt_next   = dly_cnt_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          // Address/data/direction are only ever loaded here, so they stay
          // stable through SETUP and ACCESS and hold afterwards.
          paddr_next  = req_addr_i;
          pwdata_next = req_wdata_i;
          pwrite_next = req_write_i;
          psel_next   = 1'b1;
          state_next  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_next  = 1'b1;
        wait_cnt_next = '0;
        state_next    = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready_i) begin
          psel_next    = 1'b0;
          penable_next = 1'b0;
          if (pwrite_reg) begin
            rsp_rdata_next = '0;
            rsp_err_next   = 1'b0;
            rsp_valid_next = 1'b1;
            state_next     = ST_RESP;
          end else if (RDATA_DELAY == 0) begin
            rsp_rdata_next = prdata_i;
            rsp_err_next   = 1'b0;
            rsp_valid_next = 1'b1;
            state_next     = ST_RESP;
          end else begin
            // Slave presents read data only after the access edge.
            dly_cnt_next = '0;
            state_next   = ST_RDWAIT;
          end
        end else if ((TIMEOUT_CYCLES > 0) && (wait_cnt_reg == WAIT_LAST)) begin
          // This is the TIMEOUT_CYCLES-th ACCESS cycle without pready: abort.
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end else if (wait_cnt_reg != '1) begin
          // Saturate rather than wrap when the timeout is disabled.
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end

      ST_RDWAIT: begin
        if (dly_cnt_reg == DLY_LAST) begin
          rsp_rdata_next = prdata_i;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end else begin
          dly_cnt_next = dly_cnt_reg + DLY_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        psel_next      = 1'b0;
        penable_next   = 1'b0;
        rsp_valid_next = 1'b0;
        state_next     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      dly_cnt_reg   <= '0;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      dly_cnt_reg   <= dly_cnt_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  assign busy_o      = (state_reg != ST_IDLE);
  assign psel_o      = psel_reg;
  assign penable_o   = penable_reg;
  assign pwrite_o    = pwrite_reg;
  assign paddr_o     = paddr_reg;
  assign pwdata_o    = pwdata_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_err_o   = rsp_err_reg;

endmodule

// File: tb/tb_i2c_apb_master.sv
// tb_i2c_apb_master
//   Two instances: u_dut (defaults: RDATA_DELAY=1, TIMEOUT_CYCLES=16) against
//   a register-block-like slave with programmable wait states, and u_dut_z
//   (RDATA_DELAY=0, TIMEOUT_CYCLES=0) against a combinational standard slave.
module tb_i2c_apb_master;

  localparam int TO = 16;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         ws;
    logic [7:0] exp_rd;
    logic       exp_err;
    int         exp_lat;
    int         exp_acc;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;
  logic preset = 1'b1;

  // ---------------- DUT A ----------------
  logic       req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_err, busy, psel, penable, pwrite, pready;
  logic [7:0] rsp_rdata, paddr, pwdata;
  logic [7:0] prdata = '0;

  i2c_apb_master u_dut (
    .pclk_i(pclk), .preset_i(preset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .busy_o(busy),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready)
  );

  // Slave A: memory, pready after cfg_ws wait states, read data registered
  // on the access edge (like i2c_register_block).
  logic [7:0] sl_mem [256];
  logic       sl_load = 1'b1;
  int         cfg_ws  = 0;
  int         acc_cnt = 0;

  function automatic logic [7:0] sl_init(input int i);
    if (i == 5) return 8'hA5;
    return 8'(i) ^ 8'h5A;
  endfunction

  assign pready = psel && penable && (acc_cnt >= cfg_ws);

  always @(posedge pclk) begin
    if (sl_load) begin
      for (int i = 0; i < 256; i++) sl_mem[i] <= sl_init(i);
    end else if (psel && penable) begin
      if (pready) begin
        acc_cnt <= 0;
        if (pwrite) sl_mem[paddr] <= pwdata;
        else        prdata <= sl_mem[paddr];
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  // ---------------- DUT Z ----------------
  logic       req_valid_z = 1'b0, rsp_ready_z = 1'b0, pready_z = 1'b1;
  logic [7:0] req_addr_z = '0;
  logic       req_ready_z, rsp_valid_z, rsp_err_z, busy_z, psel_z, penable_z, pwrite_z;
  logic [7:0] rsp_rdata_z, paddr_z, pwdata_z, prdata_z;

  assign prdata_z = (paddr_z == 8'h03) ? 8'h3C : 8'hEE;

  i2c_apb_master #(.TIMEOUT_CYCLES(0), .RDATA_DELAY(0)) u_dut_z (
    .pclk_i(pclk), .preset_i(preset),
    .req_valid_i(req_valid_z), .req_ready_o(req_ready_z), .req_write_i(1'b0),
    .req_addr_i(req_addr_z), .req_wdata_i(8'h00),
    .rsp_valid_o(rsp_valid_z), .rsp_ready_i(rsp_ready_z), .rsp_rdata_o(rsp_rdata_z),
    .rsp_err_o(rsp_err_z), .busy_o(busy_z),
    .psel_o(psel_z), .penable_o(penable_z), .pwrite_o(pwrite_z), .paddr_o(paddr_z),
    .pwdata_o(pwdata_z), .prdata_i(prdata_z), .pready_i(pready_z)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete transfer on DUT A; returns response, edges from accept to
  // rsp_valid, number of ACCESS cycles and whether address/data stayed stable.
  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                         input int ws, output logic [7:0] rd, output logic er,
                         output int lat, output int acc, output logic stable);
    int guard;
    cfg_ws = ws;
    @(negedge pclk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge pclk); guard++; end
    @(posedge pclk);
    @(negedge pclk);
    req_valid = 1'b0;
    lat = 0; acc = 0; stable = 1'b1;
    while (!rsp_valid && lat < 200) begin
      if (psel && (paddr !== addr || pwrite !== wr || pwdata !== wd)) stable = 1'b0;
      if (penable) acc++;
      @(negedge pclk);
      lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    $display("txn wr=%0d addr=0x%02h wd=0x%02h ws=%0d -> rd=0x%02h err=%0d lat=%0d acc=%0d",
             wr, addr, wd, ws, rd, er, lat, acc);
  endtask

  // Bounded wait for a DUT A response, then handshake it.
  task automatic take_rsp(output logic [7:0] rd, output logic er, output logic seen);
    int guard;
    guard = 0;
    while (!rsp_valid && guard < 200) begin @(negedge pclk); guard++; end
    seen = rsp_valid; rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  logic [7:0] ref_mem [256];
  vec_t       tbl [10];
  int         ws_pick [8] = '{0, 1, 2, 3, 5, 15, 16, 17};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd, wd, addr, held;
    logic       er, stable, wr, to, seen, flag;
    int         lat, acc, ws, guard;

    for (int i = 0; i < 256; i++) ref_mem[i] = sl_init(i);

    tbl[0] = '{1'b1, 8'h00, 8'h1F,  0, 8'h00, 1'b0,  2,  1};
    tbl[1] = '{1'b0, 8'h00, 8'h00,  0, 8'h1F, 1'b0,  3,  1};
    tbl[2] = '{1'b0, 8'h05, 8'h00,  0, 8'hA5, 1'b0,  3,  1};
    tbl[3] = '{1'b1, 8'h02, 8'hC3,  3, 8'h00, 1'b0,  5,  4};
    tbl[4] = '{1'b0, 8'h02, 8'h00,  3, 8'hC3, 1'b0,  6,  4};
    tbl[5] = '{1'b1, 8'h04, 8'h77, 16, 8'h00, 1'b1, 17, 16};
    tbl[6] = '{1'b0, 8'h04, 8'h00,  0, 8'h5E, 1'b0,  3,  1};
    tbl[7] = '{1'b0, 8'h01, 8'h00, 16, 8'h00, 1'b1, 17, 16};
    tbl[8] = '{1'b1, 8'h01, 8'h99, 15, 8'h00, 1'b0, 17, 16};
    tbl[9] = '{1'b0, 8'h01, 8'h00, 15, 8'h99, 1'b0, 18, 16};

    // ---- reset state ----
    repeat (2) @(posedge pclk);
    sl_load = 1'b0;
    @(negedge pclk);
    check("reset_req_ready_in_reset", 32'(req_ready), 32'd0);
    check("reset_psel", 32'(psel), 32'd0);
    check("reset_penable", 32'(penable), 32'd0);
    preset = 1'b0;
    @(negedge pclk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    check("reset_apb", {14'd0, pwrite, paddr, pwdata, psel, penable}, 32'd0);
    check("reset_req_ready_z", 32'(req_ready_z), 32'd1);

    // ---- directed table ----
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].ws, rd, er, lat, acc, stable);
      check($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
      check($sformatf("tbl%0d_access_cycles", i), acc, tbl[i].exp_acc);
      check($sformatf("tbl%0d_stable", i), 32'(stable), 32'd1);
      if (tbl[i].wr && !tbl[i].exp_err) ref_mem[tbl[i].addr] = tbl[i].wdata;
    end
    @(negedge pclk);
    check("psel_idle_after_txn", 32'(psel), 32'd0);

    // ---- response backpressure with a second request pending ----
    cfg_ws = 0;
    @(negedge pclk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05; req_wdata = 8'h00;
    @(posedge pclk);
    @(negedge pclk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h06; req_wdata = 8'h42;
    guard = 0;
    while (!rsp_valid && guard < 50) begin @(negedge pclk); guard++; end
    held = rsp_rdata;
    check("bp_rdata", 32'(held), 32'(ref_mem[5]));
    flag = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (!rsp_valid || rsp_rdata !== held || rsp_err !== 1'b0 || req_ready !== 1'b0) flag = 1'b0;
      @(negedge pclk);
    end
    check("bp_held_stable", 32'(flag), 32'd1);
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    check("bp_valid_dropped", 32'(rsp_valid), 32'd0);
    check("bp_ready_after_hs", 32'(req_ready), 32'd1);
    @(negedge pclk);
    req_valid = 1'b0;
    check("bp_second_accepted", {22'd0, psel, penable, paddr}, {22'd0, 1'b1, 1'b0, 8'h06});
    take_rsp(rd, er, seen);
    check("bp_second_rsp", {30'd0, seen, er}, {30'd0, 1'b1, 1'b0});
    ref_mem[6] = 8'h42;
    $display("txn backpressure sequence done");

    // ---- reset during ACCESS ----
    cfg_ws = 1000;
    @(negedge pclk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h07; req_wdata = 8'h11;
    @(posedge pclk);
    @(negedge pclk);
    req_valid = 1'b0;
    guard = 0;
    while (!penable && guard < 20) begin @(negedge pclk); guard++; end
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    check("rst_mid_apb", {30'd0, psel, penable}, 32'd0);
    check("rst_mid_rsp_busy", {30'd0, rsp_valid, busy}, 32'd0);
    check("rst_mid_ready_in_reset", 32'(req_ready), 32'd0);
    preset = 1'b0;
    @(negedge pclk);
    check("rst_mid_ready_after", 32'(req_ready), 32'd1);
    flag = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) flag = 1'b1;
      @(negedge pclk);
    end
    check("rst_mid_no_rsp", 32'(flag), 32'd0);
    cfg_ws = 0;
    $display("txn reset-during-access sequence done");

    // ---- randomized against the reference model ----
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 7));
      wd   = 8'($urandom);
      ws   = ws_pick[$urandom_range(0, 7)];
      to   = (ws >= TO);
      run_txn(wr, addr, wd, ws, rd, er, lat, acc, stable);
      check($sformatf("rnd%0d_rdata", n), 32'(rd), (wr || to) ? 32'd0 : 32'(ref_mem[addr]));
      check($sformatf("rnd%0d_err", n), 32'(er), 32'(to));
      check($sformatf("rnd%0d_latency", n), lat, to ? TO + 1 : 2 + ws + (wr ? 0 : 1));
      check($sformatf("rnd%0d_access_cycles", n), acc, to ? TO : ws + 1);
      check($sformatf("rnd%0d_stable", n), 32'(stable), 32'd1);
      if (wr && !to) ref_mem[addr] = wd;
    end

    // ---- DUT Z: standard APB read data, no timeout ----
    pready_z = 1'b1;
    @(negedge pclk);
    req_valid_z = 1'b1; req_addr_z = 8'h03;
    @(posedge pclk);
    @(negedge pclk);
    req_valid_z = 1'b0;
    lat = 0;
    while (!rsp_valid_z && lat < 50) begin @(negedge pclk); lat++; end
    check("z_read_latency", lat, 2);
    check("z_read_rdata", 32'(rsp_rdata_z), 32'h3C);
    check("z_read_err", 32'(rsp_err_z), 32'd0);
    rsp_ready_z = 1'b1;
    @(negedge pclk);
    rsp_ready_z = 1'b0;
    $display("txn z read addr=0x03 -> rd=0x3c");

    pready_z = 1'b0;
    @(negedge pclk);
    req_valid_z = 1'b1; req_addr_z = 8'h03;
    @(posedge pclk);
    @(negedge pclk);
    req_valid_z = 1'b0;
    flag = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid_z) flag = 1'b1;
      @(negedge pclk);
    end
    check("z_no_timeout", {30'd0, flag, penable_z}, {30'd0, 1'b0, 1'b1});
    pready_z = 1'b1;
    guard = 0;
    while (!rsp_valid_z && guard < 50) begin @(negedge pclk); guard++; end
    check("z_late_rsp", {22'd0, rsp_valid_z, rsp_err_z, rsp_rdata_z}, {22'd0, 1'b1, 1'b0, 8'h3C});
    rsp_ready_z = 1'b1;
    @(negedge pclk);
    rsp_ready_z = 1'b0;
    $display("txn z stalled read released -> rd=0x%02h", rsp_rdata_z);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
